// File: rtl/iter_alu_if.sv
// Start/busy/done request bundle for the iterative arithmetic unit.
// The controller drives the master side and the unit drives the slave side.
interface iter_alu_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] hi;
  logic             z;
  logic             dz;

  modport master (
    output start, op, a, b,
    input  busy, done, s, hi, z, dz
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, s, hi, z, dz
  );
endinterface

// File: rtl/iter_alu.sv
// Multi-cycle multiply, divide and bit-count unit beside the main ALU.
// Each operation retires one bit per cycle; results are held until the next start.
module iter_alu #(
  parameter int WIDTH = 32
) (
  input  logic        clock,
  input  logic        reset,
  iter_alu_if.slave   io
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] OP_MULU = 3'b000;
  localparam logic [2:0] OP_MUL  = 3'b001;
  localparam logic [2:0] OP_DIVU = 3'b010;
  localparam logic [2:0] OP_REMU = 3'b011;
  localparam logic [2:0] OP_HAM  = 3'b100;
  localparam logic [2:0] OP_POP  = 3'b101;

  logic [1:0]       state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             neg_q, neg_d;
  logic             fast_q, fast_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [WIDTH-1:0] rh_q, rh_d;
  logic             z_q, z_d;
  logic             dz_q, dz_d;

  logic             accept;
  logic             fast_in;
  logic             is_div_in;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     r_sh;
  logic               r_ge;
  logic [WIDTH-1:0]   it_hi;
  logic [WIDTH-1:0]   it_lo;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   res_s;
  logic [WIDTH-1:0]   res_hi;

  assign accept    = io.start && (state_q != S_RUN);
  assign is_div_in = (io.op == OP_DIVU) || (io.op == OP_REMU);
  assign fast_in   = (is_div_in && (io.b == '0)) ||
                     (io.op[2:1] == 2'b11);

  // Signed multiply runs on magnitudes; the sign is reapplied at the end.
  always_comb begin
    abs_a = io.a;
    abs_b = io.b;
    if (io.op == OP_MUL) begin
      if (io.a[WIDTH-1]) abs_a = -io.a;
      if (io.b[WIDTH-1]) abs_b = -io.b;
    end
  end

  always_comb begin
    mul_sum = {1'b0, acc_hi_q} +
              (acc_lo_q[0] ? {1'b0, opb_q} : '0);
    r_sh    = {acc_hi_q, acc_lo_q[WIDTH-1]};
    r_ge    = r_sh >= {1'b0, opb_q};
    it_hi   = acc_hi_q;
    it_lo   = acc_lo_q;
    case (op_q)
      OP_MULU, OP_MUL: begin
        it_hi = mul_sum[WIDTH:1];
        it_lo = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
      end
      OP_DIVU, OP_REMU: begin
        it_hi = WIDTH'(r_ge ? (r_sh - {1'b0, opb_q}) : r_sh);
        it_lo = {acc_lo_q[WIDTH-2:0], r_ge};
      end
      OP_HAM, OP_POP: begin
        it_hi = acc_hi_q + WIDTH'(acc_lo_q[0]);
        it_lo = acc_lo_q >> 1;
      end
      default: begin
        it_hi = acc_hi_q;
        it_lo = acc_lo_q;
      end
    endcase
  end

  assign prod   = {it_hi, it_lo};
  assign prod_s = neg_q ? -prod : prod;

  always_comb begin
    res_s  = '0;
    res_hi = '0;
    case (op_q)
      OP_MULU: begin
        res_s  = it_lo;
        res_hi = it_hi;
      end
      OP_MUL: begin
        res_s  = prod_s[WIDTH-1:0];
        res_hi = prod_s[2*WIDTH-1:WIDTH];
      end
      OP_DIVU: begin
        res_s  = it_lo;
        res_hi = it_hi;
      end
      OP_REMU: begin
        res_s  = it_hi;
        res_hi = it_lo;
      end
      OP_HAM, OP_POP: begin
        res_s  = it_hi;
      end
      default: begin
        res_s  = '0;
        res_hi = '0;
      end
    endcase
    // Fast path: the dividend is still untouched in acc_lo.
    if (fast_q) begin
      res_s  = '0;
      res_hi = '0;
      if (op_q == OP_DIVU) begin
        res_s  = '1;
        res_hi = acc_lo_q;
      end else if (op_q == OP_REMU) begin
        res_s  = acc_lo_q;
        res_hi = '1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    opb_d    = opb_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    fast_d   = fast_q;
    s_d      = s_q;
    rh_d     = rh_q;
    z_d      = z_q;
    dz_d     = dz_q;
    unique case (state_q)
      S_RUN: begin
        cnt_d    = cnt_q - CNT_ONE;
        acc_hi_d = it_hi;
        acc_lo_d = it_lo;
        if (cnt_q == CNT_ONE) begin
          state_d = S_DONE;
          s_d     = res_s;
          rh_d    = res_hi;
          z_d     = (res_s == '0);
          dz_d    = fast_q &&
                    ((op_q == OP_DIVU) || (op_q == OP_REMU));
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (accept) begin
      state_d  = S_RUN;
      op_d     = io.op;
      opb_d    = abs_b;
      acc_hi_d = '0;
      cnt_d    = fast_in ? CNT_ONE : CNT_FULL;
      neg_d    = (io.op == OP_MUL) && (io.a[WIDTH-1] ^ io.b[WIDTH-1]);
      fast_d   = fast_in;
      dz_d     = 1'b0;
      if (io.op == OP_HAM)      acc_lo_d = io.a ^ io.b;
      else if (io.op == OP_MUL) acc_lo_d = abs_a;
      else                      acc_lo_d = io.a;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      opb_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      fast_q   <= 1'b0;
      s_q      <= '0;
      rh_q     <= '0;
      z_q      <= 1'b1;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      opb_q    <= opb_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      fast_q   <= fast_d;
      s_q      <= s_d;
      rh_q     <= rh_d;
      z_q      <= z_d;
      dz_q     <= dz_d;
    end
  end

  assign io.busy = (state_q == S_RUN);
  assign io.done = (state_q == S_DONE);
  assign io.s    = s_q;
  assign io.hi   = rh_q;
  assign io.z    = z_q;
  assign io.dz   = dz_q;

endmodule

// File: tb/tb_iter_alu.sv
// Self-checking bench for iter_alu: vector table plus handshake,
// back-to-back and reset-abort sequences, checked through a scoreboard.
module tb_iter_alu;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  iter_alu_if #(.WIDTH(W)) bus();

  iter_alu #(.WIDTH(W)) dut (
    .clock (clk),
    .reset (rst),
    .io    (bus.slave)
  );

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] s;
    logic [W-1:0] hi;
    logic         z;
    logic         dz;
    int           lat;
  } vec_t;

  vec_t exp_q[$];
  vec_t vecs[18];
  int checks = 0;
  int errors = 0;

  function automatic vec_t mk(logic [2:0] op, logic [W-1:0] a,
                              logic [W-1:0] b, logic [W-1:0] s,
                              logic [W-1:0] hi, logic z, logic dz,
                              int lat);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.s = s; v.hi = hi;
    v.z = z; v.dz = dz; v.lat = lat;
    return v;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic issue(vec_t v, string tag);
    bus.start = 1'b1;
    bus.op    = v.op;
    bus.a     = v.a;
    bus.b     = v.b;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk({tag, ".busy_accept"}, 64'(bus.busy), 64'd1);
    chk({tag, ".done_accept"}, 64'(bus.done), 64'd0);
  endtask

  task automatic wait_done(string tag, int poke);
    int cyc;
    bit seen;
    vec_t e;
    cyc  = 0;
    seen = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      if (poke > 0 && i == poke) begin
        bus.start = 1'b1;
        bus.op    = 3'b101;
        bus.a     = '1;
        bus.b     = '1;
      end
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      if (bus.done) begin
        cyc  = i;
        seen = 1'b1;
        break;
      end
    end
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s.scoreboard: got empty queue expected entry", tag);
      return;
    end
    e = exp_q.pop_front();
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s.timeout: got no done expected done at %0d",
               tag, e.lat);
      return;
    end
    chk({tag, ".latency"}, 64'(cyc), 64'(e.lat));
    chk({tag, ".s"},  64'(bus.s),  64'(e.s));
    chk({tag, ".hi"}, 64'(bus.hi), 64'(e.hi));
    chk({tag, ".z"},  64'(bus.z),  64'(e.z));
    chk({tag, ".dz"}, 64'(bus.dz), 64'(e.dz));
  endtask

  task automatic run_vec(vec_t v, string tag);
    @(negedge clk);
    issue(v, tag);
    wait_done(tag, 0);
    @(posedge clk);
    #1;
    chk({tag, ".done_pulse"}, 64'(bus.done), 64'd0);
    chk({tag, ".idle_busy"},  64'(bus.busy), 64'd0);
  endtask

  initial begin
    int  seen_done;
    vec_t v1;
    vec_t v2;

    vecs[0]  = mk(3'b000, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFE, 32'h1, 0, 0, W);
    vecs[1]  = mk(3'b001, 32'hFFFFFFFD, 32'h5, 32'hFFFFFFF1, 32'hFFFFFFFF, 0, 0, W);
    vecs[2]  = mk(3'b001, 32'h80000000, 32'h80000000, 32'h0, 32'h40000000, 1, 0, W);
    vecs[3]  = mk(3'b010, 32'd100, 32'd7, 32'd14, 32'd2, 0, 0, W);
    vecs[4]  = mk(3'b011, 32'd100, 32'd7, 32'd2, 32'd14, 0, 0, W);
    vecs[5]  = mk(3'b010, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 0, 1, 1);
    vecs[6]  = mk(3'b100, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'd32, 32'd0, 0, 0, W);
    vecs[7]  = mk(3'b100, 32'h12345678, 32'h12345678, 32'd0, 32'd0, 1, 0, W);
    vecs[8]  = mk(3'b101, 32'h80000001, 32'hFFFFFFFF, 32'd2, 32'd0, 0, 0, W);
    vecs[9]  = mk(3'b111, 32'd5, 32'd6, 32'd0, 32'd0, 1, 0, 1);
    vecs[10] = mk(3'b011, 32'd9, 32'd0, 32'd9, 32'hFFFFFFFF, 0, 1, 1);
    vecs[11] = mk(3'b110, 32'd9, 32'd3, 32'd0, 32'd0, 1, 0, 1);
    vecs[12] = mk(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 32'd0, 0, 0, W);
    vecs[13] = mk(3'b001, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFF2, 32'hFFFFFFFF, 0, 0, W);
    vecs[14] = mk(3'b010, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 0, 0, W);
    vecs[15] = mk(3'b101, 32'hFFFFFFFF, 32'd0, 32'd32, 32'd0, 0, 0, W);
    vecs[16] = mk(3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 32'hFFFFFFFE, 0, 0, W);
    vecs[17] = mk(3'b011, 32'd1000, 32'd1001, 32'd1000, 32'd0, 0, 0, W);

    bus.start = 1'b0;
    bus.op    = '0;
    bus.a     = '0;
    bus.b     = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset.busy", 64'(bus.busy), 64'd0);
    chk("reset.done", 64'(bus.done), 64'd0);
    chk("reset.s",    64'(bus.s),    64'd0);
    chk("reset.hi",   64'(bus.hi),   64'd0);
    chk("reset.z",    64'(bus.z),    64'd1);
    chk("reset.dz",   64'(bus.dz),   64'd0);
    rst = 1'b0;

    for (int i = 0; i < 18; i++)
      run_vec(vecs[i], $sformatf("vec%0d", i));

    // start pulsed at edge 5 of a running multiply is ignored
    @(negedge clk);
    issue(vecs[0], "ignore");
    wait_done("ignore", 5);

    // back-to-back: new start accepted during the done cycle
    v1 = mk(3'b010, 32'd100, 32'd7, 32'd14, 32'd2, 0, 0, W);
    v2 = mk(3'b011, 32'd100, 32'd7, 32'd2, 32'd14, 0, 0, W);
    @(negedge clk);
    issue(v1, "b2b1");
    wait_done("b2b1", 0);
    issue(v2, "b2b2");
    wait_done("b2b2", 0);

    // reset at edge 10 of a divide aborts it
    @(negedge clk);
    issue(mk(3'b010, 32'd1000, 32'd3, 32'd333, 32'd1, 0, 0, W), "abort");
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort.busy", 64'(bus.busy), 64'd0);
    chk("abort.done", 64'(bus.done), 64'd0);
    chk("abort.s",    64'(bus.s),    64'd0);
    chk("abort.hi",   64'(bus.hi),   64'd0);
    chk("abort.z",    64'(bus.z),    64'd1);
    chk("abort.dz",   64'(bus.dz),   64'd0);
    void'(exp_q.pop_front());
    rst = 1'b0;
    seen_done = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) seen_done++;
    end
    chk("abort.no_done", 64'(seen_done), 64'd0);
    run_vec(mk(3'b000, 32'd3, 32'd4, 32'd12, 32'd0, 0, 0, W), "after_abort");

    chk("scoreboard.empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
